// File: rtl/fpu_wb_pipe.sv
// fpu_wb_pipe: registered writeback stage for the FP datapath.
// Delays each FP result through STAGES registers and keeps a per-register
// pending scoreboard so issue logic can detect RAW/WAW hazards on in-flight
// destinations. Supports writeback backpressure and synchronous flush.
module fpu_wb_pipe #(
  parameter int STAGES = 2,
  parameter int AW     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [AW-1:0]        in_rd,
  input  logic [31:0]          in_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_sel,
  output logic [AW-1:0]        out_rd,
  output logic [31:0]          out_res,
  input  logic [AW-1:0]        q_addr1,
  input  logic [AW-1:0]        q_addr2,
  input  logic [AW-1:0]        q_addr3,
  output logic                 q_hazard1,
  output logic                 q_hazard2,
  output logic                 q_hazard3,
  output logic [(2**AW)-1:0]   pending
);

  localparam int NREG = 2**AW;

  typedef struct packed {
    logic          valid;
    logic [1:0]    sel;
    logic [AW-1:0] rd;
    logic [31:0]   res;
  } entry_t;

  // Entry STAGES-1 is the head that faces writeback.
  entry_t stage_q [STAGES];

  logic            stall;
  logic            retire;
  logic            retire_same;
  logic            accept;
  logic [NREG-1:0] pending_nxt;

  assign out_valid = stage_q[STAGES-1].valid;
  assign out_sel   = stage_q[STAGES-1].sel;
  assign out_rd    = stage_q[STAGES-1].rd;
  assign out_res   = stage_q[STAGES-1].res;

  // The whole pipe freezes while the head is blocked; bubbles never collapse.
  assign stall       = out_valid & ~out_ready;
  assign retire      = out_valid & out_ready & ~flush;
  assign retire_same = out_valid & out_ready & (out_rd == in_rd);

  // A destination may only be re-issued once its older result is leaving,
  // which keeps at most one in-flight entry per register (WAW safety).
  assign in_ready = ~stall & ~flush & (~pending[in_rd] | retire_same);
  assign accept   = in_valid & in_ready;

  // Hazard queries look at registered state only; no same-cycle bypass.
  assign q_hazard1 = pending[q_addr1];
  assign q_hazard2 = pending[q_addr2];
  assign q_hazard3 = pending[q_addr3];

  // Next scoreboard: clear the retiring destination, then set the accepted
  // one so a same-register retire+accept leaves the bit set.
  always_comb begin
    // NOTE: default assignment first so no path leaves pending_nxt unassigned (no latch).
    pending_nxt = pending;
    if (retire) pending_nxt[out_rd] = 1'b0;
    if (accept) pending_nxt[in_rd]  = 1'b1;
  end

  // Pipeline shift/hold plus scoreboard update; flush dominates everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the entry array is tiny and also drives out_*, so every field is
      // reset (not just valid) to give defined output data after reset.
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      pending <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) stage_q[i].valid <= 1'b0;
      pending <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage reads the pre-edge value
      // of its predecessor, independent of loop order.
      pending <= pending_nxt;
      if (!stall) begin
        for (int i = STAGES - 1; i > 0; i--) stage_q[i] <= stage_q[i-1];
        stage_q[0].valid <= accept;
        stage_q[0].sel   <= in_sel;
        stage_q[0].rd    <= in_rd;
        stage_q[0].res   <= in_res;
      end
    end
  end

endmodule

// File: tb/tb_fpu_wb_pipe.sv
// Self-checking bench for fpu_wb_pipe: directed literal scenarios plus a
// randomized phase compared every cycle against a queue-based model.
module tb_fpu_wb_pipe;

  localparam int STAGES = 2;
  localparam int AW     = 5;
  localparam int NREG   = 2**AW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_sel = '0;
  logic [AW-1:0]   in_rd = '0;
  logic [31:0]     in_res = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [1:0]      out_sel;
  logic [AW-1:0]   out_rd;
  logic [31:0]     out_res;
  logic [AW-1:0]   q_addr1 = '0;
  logic [AW-1:0]   q_addr2 = '0;
  logic [AW-1:0]   q_addr3 = '0;
  logic            q_hazard1;
  logic            q_hazard2;
  logic            q_hazard3;
  logic [NREG-1:0] pending;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  fpu_wb_pipe #(.STAGES(STAGES), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_rd(in_rd), .in_res(in_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel), .out_rd(out_rd), .out_res(out_res),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_addr3(q_addr3),
    .q_hazard1(q_hazard1), .q_hazard2(q_hazard2), .q_hazard3(q_hazard3),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // In-flight results in acceptance order. 'adv' counts clock edges on which
  // the pipe moved; a result accepted on an edge reaches the head once the
  // pipe has moved STAGES-1 more times.
  typedef struct {
    logic [1:0]    sel;
    logic [AW-1:0] rd;
    logic [31:0]   res;
    int            due;
  } item_t;

  item_t q[$];
  int    adv = 0;
  bit    m_acc;
  bit    m_head;
  item_t m_new;

  function automatic bit m_ov();
    return (q.size() > 0) && (q[0].due <= adv);
  endfunction

  function automatic bit m_pend(input logic [AW-1:0] r);
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NREG-1:0] m_pend_vec();
    logic [NREG-1:0] v = '0;
    foreach (q[i]) v[q[i].rd] = 1'b1;
    return v;
  endfunction

  function automatic bit m_ready();
    bit ov;
    ov = m_ov();
    if (flush) return 1'b0;
    if (ov && !out_ready) return 1'b0;
    if (!m_pend(in_rd)) return 1'b1;
    return ov && out_ready && (q[0].rd == in_rd);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      adv = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      m_head = m_ov();
      m_acc  = in_valid && m_ready();
      if (m_head && out_ready) void'(q.pop_front());
      if (!(m_head && !out_ready)) adv++;
      if (m_acc) begin
        m_new.sel = in_sel;
        m_new.rd  = in_rd;
        m_new.res = in_res;
        m_new.due = adv + STAGES - 1;
        q.push_back(m_new);
      end
    end
  end

  // Compare process: DUT against model every cycle, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_in_ready", in_ready, m_ready());
      check("m_out_valid", out_valid, m_ov());
      if (m_ov()) begin
        check("m_out_sel", out_sel, q[0].sel);
        check("m_out_rd", out_rd, q[0].rd);
        check("m_out_res", out_res, q[0].res);
      end
      check("m_pending", pending, m_pend_vec());
      check("m_hazard1", q_hazard1, m_pend(q_addr1));
      check("m_hazard2", q_hazard2, m_pend(q_addr2));
      check("m_hazard3", q_hazard3, m_pend(q_addr3));
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [AW-1:0] r,
                       input logic [31:0] d, input bit ordy, input bit fl);
    in_valid  = v;
    in_sel    = s;
    in_rd     = r;
    in_res    = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, '0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_res", out_res, 0);
    check("rst_pending", pending, 0);
    next_cycle();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Basic latency: rd=3 accepted at cycle 0, at the head on cycle 2
    drive(1'b1, 2'd1, 5'd3, 32'h40400000, 1'b1, 1'b0);
    @(negedge clk); check("t1_in_ready", in_ready, 1);
    next_cycle(); idle();
    @(negedge clk); check("t1_c1_pend3", pending[3], 1); check("t1_c1_ov", out_valid, 0);
    next_cycle();
    @(negedge clk);
    check("t1_c2_ov", out_valid, 1); check("t1_c2_rd", out_rd, 3);
    check("t1_c2_res", out_res, 32'h40400000); check("t1_c2_sel", out_sel, 1);
    check("t1_c2_pend3", pending[3], 1);
    next_cycle();
    @(negedge clk); check("t1_c3_pend3", pending[3], 0); check("t1_c3_ov", out_valid, 0);

    // Backpressure: rd=5 held at the head for 4 stalled cycles
    next_cycle(); drive(1'b1, 2'd2, 5'd5, 32'h3f800000, 1'b1, 1'b0);
    next_cycle(); drive(1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); drive(1'b1, 2'd0, 5'd6, 32'hdeadbeef, 1'b0, 1'b0);
      @(negedge clk);
      check("t2_ov", out_valid, 1); check("t2_rd", out_rd, 5);
      check("t2_res", out_res, 32'h3f800000); check("t2_in_ready", in_ready, 0);
      check("t2_pend5", pending[5], 1);
    end
    next_cycle(); idle();
    @(negedge clk); check("t2_rel_ov", out_valid, 1);
    next_cycle();
    @(negedge clk); check("t2_after_ov", out_valid, 0); check("t2_after_pend5", pending[5], 0);

    // WAW on rd=7
    next_cycle(); drive(1'b1, 2'd0, 5'd7, 32'h11111111, 1'b1, 1'b0);
    next_cycle(); drive(1'b1, 2'd3, 5'd7, 32'h22222222, 1'b1, 1'b0);
    @(negedge clk); check("t3_blocked", in_ready, 0);
    next_cycle();
    @(negedge clk);
    check("t3_ready_at_retire", in_ready, 1); check("t3_head_rd", out_rd, 7);
    check("t3_head_res", out_res, 32'h11111111);
    next_cycle(); idle();
    @(negedge clk); check("t3_pend7_kept", pending[7], 1); check("t3_bubble", out_valid, 0);
    next_cycle();
    @(negedge clk);
    check("t3_second_ov", out_valid, 1); check("t3_second_res", out_res, 32'h22222222);
    check("t3_second_sel", out_sel, 3);
    next_cycle();
    @(negedge clk); check("t3_pend7_clear", pending[7], 0);

    // RAW query
    q_addr1 = 5'd10; q_addr2 = 5'd11; q_addr3 = 5'd10;
    next_cycle(); drive(1'b1, 2'd2, 5'd10, 32'hc0000000, 1'b1, 1'b0);
    next_cycle(); idle();
    @(negedge clk);
    check("t4_hz1", q_hazard1, 1); check("t4_hz2", q_hazard2, 0); check("t4_hz3", q_hazard3, 1);
    next_cycle();
    next_cycle();
    @(negedge clk); check("t4_hz1_after", q_hazard1, 0); check("t4_hz3_after", q_hazard3, 0);

    // Flush with rd=1 and rd=2 in flight
    next_cycle(); drive(1'b1, 2'd0, 5'd1, 32'h0000000a, 1'b1, 1'b0);
    next_cycle(); drive(1'b1, 2'd0, 5'd2, 32'h0000000b, 1'b1, 1'b0);
    next_cycle(); drive(1'b1, 2'd0, 5'd4, 32'h0000000d, 1'b1, 1'b1);
    @(negedge clk); check("t5_flush_in_ready", in_ready, 0);
    next_cycle(); drive(1'b1, 2'd0, 5'd1, 32'h0000000c, 1'b1, 1'b0);
    @(negedge clk);
    check("t5_ov", out_valid, 0); check("t5_pending", pending, 0); check("t5_in_ready", in_ready, 1);
    next_cycle(); idle();
    next_cycle();
    @(negedge clk); check("t5_new_res", out_res, 32'h0000000c);

    // Asynchronous reset with two valid entries
    next_cycle(); drive(1'b1, 2'd0, 5'd1, 32'h00000001, 1'b1, 1'b0);
    next_cycle(); drive(1'b1, 2'd0, 5'd2, 32'h00000002, 1'b1, 1'b0);
    next_cycle(); drive(1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_ov", out_valid, 0); check("t6_async_pending", pending, 0);
    next_cycle(); rst = 1'b0; drive(1'b1, 2'd1, 5'd4, 32'h40800000, 1'b1, 1'b0);
    next_cycle(); idle();
    next_cycle();
    @(negedge clk);
    check("t6_resume_ov", out_valid, 1); check("t6_resume_res", out_res, 32'h40800000);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      in_valid  = ($urandom_range(0, 9) < 6);
      in_sel    = 2'($urandom_range(0, 3));
      in_rd     = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1))
                                              : AW'($urandom_range(0, 5));
      in_res    = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      q_addr1   = AW'($urandom_range(0, 7));
      q_addr2   = AW'($urandom_range(0, 7));
      q_addr3   = AW'($urandom_range(0, NREG - 1));
    end

    next_cycle(); idle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
